mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_if.sv | 48 ++++
 rtl/mem_arbiter.sv | 187 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the three buses around the memory arbiter.
//   Fetch side : i_req, i_addr (to arbiter), i_data, i_ack (from arbiter)
//   Data side  : d_ren, d_wen, d_addr, d_wdata (to arbiter),
//                d_rdata, d_ack (from arbiter)
//   Memory side: m_req, m_we, m_addr, m_wdata (from arbiter),
//                m_rdata, m_ack (to arbiter)
//   Status     : stall, timeout_err (from arbiter)
// Modports:
//   slave  - the arbiter itself
//   master - the environment (core plus memory) that talks to the arbiter
// ---------------------------------------------------------------------------
interface mem_arbiter_if;
   logic        i_req;
   logic [31:0] i_addr;
   logic [31:0] i_data;
   logic        i_ack;

   logic        d_ren;
   logic        d_wen;
   logic [31:0] d_addr;
   logic [31:0] d_wdata;
   logic [31:0] d_rdata;
   logic        d_ack;

   logic        m_req;
   logic        m_we;
   logic [31:0] m_addr;
   logic [31:0] m_wdata;
   logic [31:0] m_rdata;
   logic        m_ack;

   logic        stall;
   logic        timeout_err;

   modport slave (
      input  i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, m_rdata, m_ack,
      output i_data, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
             stall, timeout_err
   );

   modport master (
      output i_req, i_addr, d_ren, d_wen, d_addr, d_wdata, m_rdata, m_ack,
      input  i_data, i_ack, d_rdata, d_ack, m_req, m_we, m_addr, m_wdata,
             stall, timeout_err
   );
endinterface

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
// Shares one memory port between an instruction-fetch requester and a data
// requester. Exactly one memory access is outstanding at a time. A granted
// access stays on the memory bus until m_ack or until MAX_WAIT wait cycles
// elapse, after which it is aborted with read data 32'hDEADBEEF and a
// timeout_err pulse alongside the requester's ack.
//
// Parameters:
//   MAX_WAIT  - wait-counter value at which an unanswered access is aborted
//               (1..255)
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   bus       - mem_arbiter_if.slave (fetch, data, memory and status buses)
//
// Optional feature macro ARB_RR_EN:
//   defined   - on simultaneous fetch and data requests, grant the side that
//               did not get the previous grant (last-grant flag resets to
//               "data", so the first contended grant goes to fetch)
//   undefined - fixed priority, data always wins over fetch
// ---------------------------------------------------------------------------
module mem_arbiter #(
   parameter int unsigned MAX_WAIT = 15
) (
   input  logic          clk,
   input  logic          rst,
   mem_arbiter_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE,
      BUSY_I,
      BUSY_D,
      DONE
   } state_t;

   localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);
   localparam logic [31:0] TIMEOUT_WORD = 32'hDEADBEEF;

   state_t      state;
   state_t      state_next;
   logic [7:0]  wait_cnt;
   logic [7:0]  wait_cnt_next;

   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic        lat_we;
   logic        grant_data;
   logic        timed_out;
   logic [31:0] i_data_q;
   logic [31:0] d_rdata_q;

   logic        data_req;
   logic        pick_data;
   logic        grant_now;
   logic        reply_now;
   logic        timeout_now;
   logic        busy;
   logic [31:0] captured_word;

`ifdef ARB_RR_EN
   logic        last_data;
`endif

   assign data_req = bus.d_ren | bus.d_wen;

   // Pick the side to grant when leaving IDLE. With round-robin enabled a
   // contended request goes to whichever side did not win last time; an
   // uncontended request always goes to whoever is asking.
`ifdef ARB_RR_EN
   assign pick_data = data_req & (~bus.i_req | ~last_data);
`else
   assign pick_data = data_req;
`endif

   // Next-state logic. IDLE grants, BUSY waits for the memory reply or the
   // timeout, DONE is the single ack cycle and never grants, so the two
   // requesters always see at least one IDLE cycle between accesses.
   always_comb begin
      state_next    = state;
      wait_cnt_next = wait_cnt;
      grant_now     = 1'b0;
      reply_now     = 1'b0;
      timeout_now   = 1'b0;
      case (state)
         IDLE: begin
            if (data_req | bus.i_req) begin
               grant_now     = 1'b1;
               wait_cnt_next = 8'd0;
               state_next    = pick_data ? BUSY_D : BUSY_I;
            end
         end
         BUSY_I, BUSY_D: begin
            if (bus.m_ack) begin
               reply_now  = 1'b1;
               state_next = DONE;
            end else if (wait_cnt == MAX_WAIT_CNT) begin
               timeout_now = 1'b1;
               state_next  = DONE;
            end else begin
               wait_cnt_next = wait_cnt + 8'd1;
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign captured_word = timeout_now ? TIMEOUT_WORD : bus.m_rdata;

   // State register and wait counter. Reset can land mid-access; it simply
   // drops the access, so no ack or timeout pulse is ever produced for it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_next;
         wait_cnt <= wait_cnt_next;
      end
   end

   // Access latch and read-data capture. Address, write data and write
   // strobe are frozen at grant time so the memory bus is stable for the
   // whole access. A fetch carries no write data. Asserting both d_ren and
   // d_wen counts as a write. Read data is held until the next completion
   // for the same side.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
         lat_we     <= 1'b0;
         grant_data <= 1'b0;
         timed_out  <= 1'b0;
         i_data_q   <= 32'd0;
         d_rdata_q  <= 32'd0;
      end else begin
         if (grant_now) begin
            lat_addr   <= pick_data ? bus.d_addr : bus.i_addr;
            lat_wdata  <= pick_data ? bus.d_wdata : 32'd0;
            lat_we     <= pick_data & bus.d_wen;
            grant_data <= pick_data;
            timed_out  <= 1'b0;
         end
         if (reply_now | timeout_now) begin
            timed_out <= timeout_now;
            if (grant_data) begin
               d_rdata_q <= captured_word;
            end else begin
               i_data_q <= captured_word;
            end
         end
      end
   end

`ifdef ARB_RR_EN
   // Last-grant flag for round-robin; starts out as "data served last".
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         last_data <= 1'b1;
      end else if (grant_now) begin
         last_data <= pick_data;
      end
   end
`endif

   // Output decode. The memory bus is driven only while an access is in
   // flight and is all-zero otherwise. Stall is combinational so the core
   // releases its stage enables in the very cycle the ack arrives.
   assign busy            = (state == BUSY_I) | (state == BUSY_D);
   assign bus.m_req       = busy;
   assign bus.m_we        = (state == BUSY_D) & lat_we;
   assign bus.m_addr      = busy ? lat_addr  : 32'd0;
   assign bus.m_wdata     = busy ? lat_wdata : 32'd0;
   assign bus.i_ack       = (state == DONE) & ~grant_data;
   assign bus.d_ack       = (state == DONE) &  grant_data;
   assign bus.timeout_err = (state == DONE) &  timed_out;
   assign bus.i_data      = i_data_q;
   assign bus.d_rdata     = d_rdata_q;
   assign bus.stall       = (bus.i_req & ~bus.i_ack) | (data_req & ~bus.d_ack);

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter with MAX_WAIT = 3. A small transaction
// model predicts every output each cycle; directed scenarios additionally
// pin hand-computed values (latencies, data words, grant order).
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

   localparam int MAX_WAIT = 3;

   logic clk = 1'b0;
   logic rst = 1'b1;

   always #5 clk = ~clk;

   mem_arbiter_if bus();

   mem_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int assertCount = 0;
   int failCount   = 0;

   int          ackDelay = 1;
   logic [31:0] memData  = 32'd0;
   bit          strayAck = 1'b0;
   bit          simDone  = 1'b0;

   // One comparison: count it, report it only when it goes wrong.
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      assertCount++;
      if (actual !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   task automatic checkBit(input string name, input logic actual, input logic expected);
      checkOutput(name, {31'd0, actual}, {31'd0, expected});
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic ir, input logic [31:0] ia,
                                input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] dwd);
      bus.i_req   = ir;
      bus.i_addr  = ia;
      bus.d_ren   = dr;
      bus.d_wen   = dw;
      bus.d_addr  = da;
      bus.d_wdata = dwd;
   endtask

   // Wait for the next ack; latency counts negedges, the first being the
   // cycle the request is presented in. A missing ack is a failed check.
   task automatic waitAck(input string name, output int latency, output bit sawData);
      latency = -1;
      sawData = 1'b0;
      for (int c = 0; c < 40; c++) begin
         @(negedge clk);
         if (bus.i_ack || bus.d_ack) begin
            latency = c;
            sawData = bus.d_ack;
            return;
         end
      end
      assertCount++;
      failCount++;
      $display("[TB] FAIL %s: no ack within 40 cycles", name);
   endtask

   // Memory responder: answers the access on its ackDelay-th cycle on the
   // bus (0 = never). Off-bus it can raise stray acks. Non-reply cycles
   // carry junk read data so that any wrong capture is visible.
   initial begin
      int busyCnt;
      busyCnt     = 0;
      bus.m_ack   = 1'b0;
      bus.m_rdata = 32'd0;
      forever begin
         @(posedge clk);
         #1;
         if (rst || !bus.m_req) begin
            busyCnt     = 0;
            bus.m_ack   = strayAck & ~rst;
            bus.m_rdata = ~memData;
         end else begin
            busyCnt++;
            if (ackDelay != 0 && busyCnt == ackDelay) begin
               bus.m_ack   = 1'b1;
               bus.m_rdata = memData;
            end else begin
               bus.m_ack   = 1'b0;
               bus.m_rdata = ~memData;
            end
         end
      end
   end

   // Transaction model: an access is either absent, in flight (counting how
   // many cycles it has waited unanswered), or completing (its ack cycle).
   bit          mBusy     = 1'b0;
   bit          mDone     = 1'b0;
   bit          mData     = 1'b0;
   bit          mWe       = 1'b0;
   bit          mTimeout  = 1'b0;
   bit          mLastData = 1'b1;
   logic [31:0] mAddr     = 32'd0;
   logic [31:0] mWdata    = 32'd0;
   logic [31:0] mIData    = 32'd0;
   logic [31:0] mDData    = 32'd0;
   int          mWaited   = 0;

   initial begin
      forever begin
         @(posedge clk or posedge rst);
         if (rst) begin
            mBusy = 0; mDone = 0; mData = 0; mWe = 0; mTimeout = 0;
            mLastData = 1; mAddr = 0; mWdata = 0; mIData = 0; mDData = 0;
            mWaited = 0;
         end else if (mDone) begin
            mDone = 0;
         end else if (mBusy) begin
            if (bus.m_ack || mWaited == MAX_WAIT) begin
               mTimeout = !bus.m_ack;
               if (mData) mDData = bus.m_ack ? bus.m_rdata : 32'hDEADBEEF;
               else       mIData = bus.m_ack ? bus.m_rdata : 32'hDEADBEEF;
               mBusy = 0;
               mDone = 1;
            end else begin
               mWaited++;
            end
         end else if (bus.d_ren || bus.d_wen || bus.i_req) begin
            bit wantD;
            wantD = bus.d_ren || bus.d_wen;
`ifdef ARB_RR_EN
            if (wantD && bus.i_req) wantD = !mLastData;
`endif
            mLastData = wantD;
            mData     = wantD;
            mAddr     = wantD ? bus.d_addr : bus.i_addr;
            mWdata    = wantD ? bus.d_wdata : 32'd0;
            mWe       = wantD && bus.d_wen;
            mBusy     = 1;
            mWaited   = 0;
         end
      end
   end

   // Every-cycle comparison of all DUT outputs against the model.
   initial begin
      @(negedge clk);
      while (!simDone) begin
         logic expIAck, expDAck;
         expIAck = mDone && !mData;
         expDAck = mDone && mData;
         checkBit("m_req", bus.m_req, mBusy);
         checkBit("m_we", bus.m_we, mBusy && mWe);
         checkOutput("m_addr", bus.m_addr, mBusy ? mAddr : 32'd0);
         checkOutput("m_wdata", bus.m_wdata, mBusy ? mWdata : 32'd0);
         checkBit("i_ack", bus.i_ack, expIAck);
         checkBit("d_ack", bus.d_ack, expDAck);
         checkBit("timeout_err", bus.timeout_err, mDone && mTimeout);
         checkOutput("i_data", bus.i_data, mIData);
         checkOutput("d_rdata", bus.d_rdata, mDData);
         checkBit("stall", bus.stall,
                  (bus.i_req && !expIAck) || ((bus.d_ren || bus.d_wen) && !expDAck));
         @(negedge clk);
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed scenarios.
   initial begin
      int lat;
      bit side;
      bit sides [3];

      applyStimulus(0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      checkBit("reset m_req", bus.m_req, 1'b0);
      checkBit("reset i_ack", bus.i_ack, 1'b0);
      checkBit("reset d_ack", bus.d_ack, 1'b0);
      checkBit("reset stall", bus.stall, 1'b0);
      checkOutput("reset i_data", bus.i_data, 32'd0);
      checkOutput("reset d_rdata", bus.d_rdata, 32'd0);
      nextCycle();
      rst = 1'b0;
      nextCycle();

      $display("[TB] single fetch");
      ackDelay = 1;
      memData  = 32'h2402000A;
      applyStimulus(1, 32'h100, 0, 0, 0, 0);
      waitAck("fetch ack", lat, side);
      checkOutput("fetch latency", 32'(lat), 32'd2);
      checkBit("fetch side", side, 1'b0);
      checkOutput("fetch i_data", bus.i_data, 32'h2402000A);
      checkBit("fetch stall at ack", bus.stall, 1'b0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkBit("fetch stall after", bus.stall, 1'b0);
      checkBit("fetch ack one cycle", bus.i_ack, 1'b0);

      $display("[TB] store");
      nextCycle();
      ackDelay = 2;
      memData  = 32'h11111111;
      applyStimulus(0, 0, 0, 1, 32'h40, 32'h55);
      @(negedge clk);
      @(negedge clk);
      checkBit("store m_req", bus.m_req, 1'b1);
      checkBit("store m_we", bus.m_we, 1'b1);
      checkOutput("store m_addr", bus.m_addr, 32'h40);
      checkOutput("store m_wdata", bus.m_wdata, 32'h55);
      waitAck("store ack", lat, side);
      checkOutput("store latency", 32'(lat), 32'd1);
      checkBit("store side", side, 1'b1);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkBit("store ack one cycle", bus.d_ack, 1'b0);

      $display("[TB] contention");
      nextCycle();
      ackDelay = 1;
      memData  = 32'hA5A50001;
      applyStimulus(1, 32'h200, 1, 0, 32'h300, 0);
      for (int r = 0; r < 3; r++) begin
         waitAck("contention ack", lat, side);
         sides[r] = side;
         checkOutput("contention latency", 32'(lat), 32'd2);
      end
`ifdef ARB_RR_EN
      checkBit("rr round 1", sides[0], 1'b0);
      checkBit("rr round 2", sides[1], 1'b1);
      checkBit("rr round 3", sides[2], 1'b0);
`else
      checkBit("fixed round 1", sides[0], 1'b1);
      checkBit("fixed round 2", sides[1], 1'b1);
      checkBit("fixed round 3", sides[2], 1'b1);
`endif
      nextCycle();
      applyStimulus(1, 32'h200, 0, 0, 0, 0);
      waitAck("starved fetch ack", lat, side);
      checkBit("starved fetch side", side, 1'b0);
      checkOutput("starved fetch i_data", bus.i_data, 32'hA5A50001);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);

      $display("[TB] timeout");
      nextCycle();
      ackDelay = 0;
      memData  = 32'h77777777;
      applyStimulus(0, 0, 1, 0, 32'h80, 0);
      waitAck("timeout ack", lat, side);
      checkOutput("timeout latency", 32'(lat), 32'd5);
      checkBit("timeout side", side, 1'b1);
      checkBit("timeout_err with ack", bus.timeout_err, 1'b1);
      checkOutput("timeout d_rdata", bus.d_rdata, 32'hDEADBEEF);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      @(negedge clk);
      checkBit("timeout_err one cycle", bus.timeout_err, 1'b0);

      for (int d = 3; d <= 4; d++) begin
         nextCycle();
         ackDelay = d;
         memData  = 32'hCAFE0000 + 32'(d);
         applyStimulus(0, 0, 1, 0, 32'h84, 0);
         waitAck("late reply ack", lat, side);
         checkOutput("late reply latency", 32'(lat), 32'(d + 1));
         checkBit("late reply no timeout", bus.timeout_err, 1'b0);
         checkOutput("late reply d_rdata", bus.d_rdata, 32'hCAFE0000 + 32'(d));
         nextCycle();
         applyStimulus(0, 0, 0, 0, 0, 0);
      end

      $display("[TB] stray acks while idle");
      strayAck = 1'b1;
      repeat (3) begin
         nextCycle();
         @(negedge clk);
         checkBit("stray m_req", bus.m_req, 1'b0);
         checkBit("stray d_ack", bus.d_ack, 1'b0);
         checkOutput("stray d_rdata", bus.d_rdata, 32'hCAFE0004);
      end
      strayAck = 1'b0;

      $display("[TB] reset during fetch");
      nextCycle();
      ackDelay = 0;
      applyStimulus(1, 32'h500, 0, 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      checkBit("pre-reset m_req", bus.m_req, 1'b1);
      #2;
      rst = 1'b1;
      #1;
      checkBit("reset m_req drop", bus.m_req, 1'b0);
      checkOutput("reset m_addr drop", bus.m_addr, 32'd0);
      checkOutput("reset clears i_data", bus.i_data, 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (2) nextCycle();
      rst = 1'b0;
      @(negedge clk);
      checkBit("no ack after reset", bus.i_ack, 1'b0);
      nextCycle();
      ackDelay = 1;
      memData  = 32'h12345678;
      applyStimulus(1, 32'h600, 0, 0, 0, 0);
      waitAck("post-reset fetch ack", lat, side);
      checkOutput("post-reset latency", 32'(lat), 32'd2);
      checkOutput("post-reset i_data", bus.i_data, 32'h12345678);
      checkBit("post-reset no timeout", bus.timeout_err, 1'b0);
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 0);
      repeat (3) nextCycle();

      simDone = 1'b1;
      @(negedge clk);
      #1;
      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
